// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: redirect-source enum
// and alignment-width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_BR,
    SRC_RET,
    SRC_CALL,
    SRC_JMP,
    SRC_HOLD,
    SRC_SEQ
  } src_e;

  // Number of low target bits forced to zero for a given step.
  function automatic int unsigned align_bits(int unsigned step);
    return (step <= 1) ? 0 : $clog2(step);
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Request/response bundle of the PC sequencer.
// master drives stall/exc/br/jmp/call/ret; slave returns pc and RAS flags.
interface pc_seq_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             exc;
  logic             br_taken;
  logic [WIDTH-1:0] br_tgt;
  logic             jmp;
  logic             call;
  logic [WIDTH-1:0] jmp_tgt;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [CW-1:0]    ras_count;
  logic             ras_ovf;
  logic             ret_err;
  logic             misalign;

  modport master (
    output stall, exc, br_taken, br_tgt,
    output jmp, call, jmp_tgt, ret,
    input  pc, pc_plus, ras_count,
    input  ras_ovf, ret_err, misalign
  );

  modport slave (
    input  stall, exc, br_taken, br_tgt,
    input  jmp, call, jmp_tgt, ret,
    output pc, pc_plus, ras_count,
    output ras_ovf, ret_err, misalign
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Ports: push/pop/flush/push_data in; top/count/ovf (sticky) out.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       ovf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full;

  // ptr_q is the next write slot; top sits just below it.
  always_comb begin
    full  = (cnt_q == CW'(RAS_DEPTH));
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push) begin
      ptr_d = ptr_q + 1'b1;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entries are never cleared; count alone says what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush)
      mem_q[ptr_q] <= push_data;
  end

  assign top   = mem_q[ptr_q - 1'b1];
  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch PC sequencer: step, hold, or single-cycle redirect with RAS.
// Ports: clk, rst_n (sync, active-low), bus (pc_seq_unit_if.slave).
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_seq_unit_if.slave bus
);
  localparam int AB = align_bits(STEP);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [WIDTH-1:0] LOW_MASK =
    WIDTH'((64'd1 << AB) - 64'd1);

  src_e             src;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ret_err_q, ret_err_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_cnt;
  logic             ras_ovf;
  logic             ras_empty;
  logic             push, pop, flush;

  assign pc_plus   = pc_q + WIDTH'(STEP);
  assign ras_empty = (ras_cnt == '0);

  // stall ranks above ret/call/jmp but below exc/br.
  always_comb begin
    if (bus.exc)           src = SRC_EXC;
    else if (bus.br_taken) src = SRC_BR;
    else if (bus.stall)    src = SRC_HOLD;
    else if (bus.ret)      src = SRC_RET;
    else if (bus.call)     src = SRC_CALL;
    else if (bus.jmp)      src = SRC_JMP;
    else                   src = SRC_SEQ;
  end

  always_comb begin
    pc_d      = pc_q;
    ret_err_d = 1'b0;
    mis_d     = 1'b0;
    unique case (src)
      SRC_EXC:  pc_d = EXC_VEC;
      SRC_BR: begin
        pc_d  = bus.br_tgt & ~LOW_MASK;
        mis_d = |(bus.br_tgt & LOW_MASK);
      end
      SRC_RET: begin
        pc_d      = ras_empty ? pc_plus : ras_top;
        ret_err_d = ras_empty;
      end
      SRC_CALL, SRC_JMP: begin
        pc_d  = bus.jmp_tgt & ~LOW_MASK;
        mis_d = |(bus.jmp_tgt & LOW_MASK);
      end
      SRC_HOLD: pc_d = pc_q;
      SRC_SEQ:  pc_d = pc_plus;
      default:  pc_d = pc_q;
    endcase
  end

  assign push  = (src == SRC_CALL);
  assign pop   = (src == SRC_RET) && !ras_empty;
  assign flush = (src == SRC_EXC);

  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_data(pc_plus),
    .top      (ras_top),
    .count    (ras_cnt),
    .ovf      (ras_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      ret_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ret_err_q <= ret_err_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.ras_count = ras_cnt;
  assign bus.ras_ovf   = ras_ovf;
  assign bus.ret_err   = ret_err_q;
  assign bus.misalign  = mis_q;

endmodule
